// File: rtl/sync_fifo_thr.sv
// -----------------------------------------------------------------------------
// sync_fifo_thr
//
// Single-clock FIFO for buffering within one clock domain. It supports any
// depth of 2 or more, programmable almost-full and almost-empty thresholds,
// an occupancy count, a selectable read mode and sticky error flags.
//
// Ports
//   CLK           single clock, rising edge
//   RST           synchronous active-low reset
//   W_INC         write request
//   WR_DATA       write data
//   R_INC         read request (in FWFT mode this acknowledges a pop)
//   RD_DATA       read data
//   RD_VALID      RD_DATA holds valid data
//   FULL          COUNT == FIFO_DEPTH
//   EMPTY         COUNT == 0
//   ALMOST_FULL   COUNT >= AFULL_THR
//   ALMOST_EMPTY  COUNT <= AEMPTY_THR
//   COUNT         current occupancy
//   OVERFLOW      sticky: a write was rejected
//   UNDERFLOW     sticky: a read was rejected
//   CLR_ERR       clears OVERFLOW and UNDERFLOW
//
// Parameters
//   DATA_WIDTH    data word width
//   FIFO_DEPTH    number of entries (any value >= 2)
//   ADDRESS_WIDTH pointer width, 2**ADDRESS_WIDTH >= FIFO_DEPTH
//   AFULL_THR     almost-full threshold
//   AEMPTY_THR    almost-empty threshold
//   FWFT          0 = registered read (1-cycle latency), 1 = first-word-fall-through
// -----------------------------------------------------------------------------
module sync_fifo_thr #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int AFULL_THR     = 6,
  parameter int AEMPTY_THR    = 2,
  parameter int FWFT          = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   W_INC,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   R_INC,
  output logic [DATA_WIDTH-1:0]  RD_DATA,
  output logic                   RD_VALID,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   ALMOST_FULL,
  output logic                   ALMOST_EMPTY,
  output logic [ADDRESS_WIDTH:0] COUNT,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW,
  input  logic                   CLR_ERR
);

  localparam int CW = ADDRESS_WIDTH + 1;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR   = ADDRESS_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]            DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]            AFULL_CNT  = CW'(AFULL_THR);
  localparam logic [CW-1:0]            AEMPTY_CNT = CW'(AEMPTY_THR);

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]            count_next;
  logic                     wr_ok;
  logic                     rd_ok;

  // Pointers wrap at FIFO_DEPTH-1, so any depth works, not only powers of two.
  function automatic logic [ADDRESS_WIDTH-1:0] ptr_inc(input logic [ADDRESS_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Acceptance uses only registered flags, so there is no combinational path
  // from the request inputs to any flag. A full FIFO still takes a write when
  // a read frees a slot on the same edge.
  assign rd_ok = R_INC & ~EMPTY;
  assign wr_ok = W_INC & (~FULL | rd_ok);

  // NOTE: every variable assigned in a combinational block gets a default
  // first; a missing assignment on some path would infer a latch.
  always_comb begin
    count_next = COUNT;
    if (wr_ok && !rd_ok)      count_next = COUNT + 1'b1;
    else if (rd_ok && !wr_ok) count_next = COUNT - 1'b1;
  end

  // NOTE: the storage array has no reset; clearing it would only cost logic,
  // because the pointers and COUNT already make stale entries unreachable.
  // Writes are blocked while reset is held so a reset edge never stores data.
  always_ff @(posedge CLK) begin
    if (RST && wr_ok) mem[wr_ptr] <= WR_DATA;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_FULL  <= 1'b0;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      COUNT        <= count_next;
      // Flags come from the next count so they move on the same edge as COUNT.
      FULL         <= (count_next == DEPTH_CNT);
      EMPTY        <= (count_next == '0);
      ALMOST_FULL  <= (count_next >= AFULL_CNT);
      ALMOST_EMPTY <= (count_next <= AEMPTY_CNT);
      // A new rejection beats a clear request in the same cycle.
      OVERFLOW     <= (W_INC & ~wr_ok) | (OVERFLOW  & ~CLR_ERR);
      UNDERFLOW    <= (R_INC & ~rd_ok) | (UNDERFLOW & ~CLR_ERR);
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // RD_DATA holds the last popped word; RD_VALID pulses for one cycle
      // after each accepted read.
      always_ff @(posedge CLK) begin
        if (!RST) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) rd_data_q <= mem[rd_ptr];
        end
      end

      assign RD_DATA  = rd_data_q;
      assign RD_VALID = rd_valid_q;
    end else begin : g_fwft
      // The head entry is presented directly. It is forced to zero while
      // empty so the output never shows a stale or uninitialised entry.
      assign RD_DATA  = EMPTY ? '0 : mem[rd_ptr];
      assign RD_VALID = ~EMPTY;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_thr.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_thr
//
// Self-checking bench for sync_fifo_thr. Three instances are built:
//   0: default parameters, registered read
//   1: FIFO_DEPTH = 5, AFULL_THR = 4, AEMPTY_THR = 1, registered read
//   2: default parameters, FWFT
// Each instance runs directed steps and then random traffic. A queue-based
// reference model predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_thr;

  logic clk;

  logic [2:0]      rst;
  logic [2:0]      w_inc;
  logic [2:0]      r_inc;
  logic [2:0]      clr_err;
  logic [2:0][7:0] wr_data;
  logic [2:0][7:0] rd_data;
  logic [2:0]      rd_valid;
  logic [2:0]      full;
  logic [2:0]      empty;
  logic [2:0]      afull;
  logic [2:0]      aempty;
  logic [2:0][3:0] count;
  logic [2:0]      ovf;
  logic [2:0]      unf;

  int checks;
  int errors;

  // Reference model state for the instance under test.
  int         depth_m;
  int         afull_m;
  int         aempty_m;
  bit         fwft_m;
  logic [7:0] q[$];
  bit         ovf_m;
  bit         unf_m;
  bit         rv_m;
  logic [7:0] rd_m;

  sync_fifo_thr u_def (
    .CLK(clk), .RST(rst[0]), .W_INC(w_inc[0]), .WR_DATA(wr_data[0]),
    .R_INC(r_inc[0]), .RD_DATA(rd_data[0]), .RD_VALID(rd_valid[0]),
    .FULL(full[0]), .EMPTY(empty[0]), .ALMOST_FULL(afull[0]),
    .ALMOST_EMPTY(aempty[0]), .COUNT(count[0]), .OVERFLOW(ovf[0]),
    .UNDERFLOW(unf[0]), .CLR_ERR(clr_err[0])
  );

  sync_fifo_thr #(
    .FIFO_DEPTH(5), .ADDRESS_WIDTH(3), .AFULL_THR(4), .AEMPTY_THR(1)
  ) u_d5 (
    .CLK(clk), .RST(rst[1]), .W_INC(w_inc[1]), .WR_DATA(wr_data[1]),
    .R_INC(r_inc[1]), .RD_DATA(rd_data[1]), .RD_VALID(rd_valid[1]),
    .FULL(full[1]), .EMPTY(empty[1]), .ALMOST_FULL(afull[1]),
    .ALMOST_EMPTY(aempty[1]), .COUNT(count[1]), .OVERFLOW(ovf[1]),
    .UNDERFLOW(unf[1]), .CLR_ERR(clr_err[1])
  );

  sync_fifo_thr #(.FWFT(1)) u_fw (
    .CLK(clk), .RST(rst[2]), .W_INC(w_inc[2]), .WR_DATA(wr_data[2]),
    .R_INC(r_inc[2]), .RD_DATA(rd_data[2]), .RD_VALID(rd_valid[2]),
    .FULL(full[2]), .EMPTY(empty[2]), .ALMOST_FULL(afull[2]),
    .ALMOST_EMPTY(aempty[2]), .COUNT(count[2]), .OVERFLOW(ovf[2]),
    .UNDERFLOW(unf[2]), .CLR_ERR(clr_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input int depth, input int athr, input int ethr, input bit fw);
    depth_m  = depth;
    afull_m  = athr;
    aempty_m = ethr;
    fwft_m   = fw;
  endtask

  // Compare every output of instance u against the model.
  task automatic compare(input int u, input string tag);
    int n;
    n = q.size();
    check($sformatf("%s u%0d count", tag, u),  32'(count[u]),  32'(n));
    check($sformatf("%s u%0d full", tag, u),   32'(full[u]),   32'(n == depth_m));
    check($sformatf("%s u%0d empty", tag, u),  32'(empty[u]),  32'(n == 0));
    check($sformatf("%s u%0d afull", tag, u),  32'(afull[u]),  32'(n >= afull_m));
    check($sformatf("%s u%0d aempty", tag, u), 32'(aempty[u]), 32'(n <= aempty_m));
    check($sformatf("%s u%0d ovf", tag, u),    32'(ovf[u]),    32'(ovf_m));
    check($sformatf("%s u%0d unf", tag, u),    32'(unf[u]),    32'(unf_m));
    if (!fwft_m) begin
      check($sformatf("%s u%0d rd_valid", tag, u), 32'(rd_valid[u]), 32'(rv_m));
      check($sformatf("%s u%0d rd_data", tag, u),  32'(rd_data[u]),  32'(rd_m));
    end else begin
      check($sformatf("%s u%0d rd_valid", tag, u), 32'(rd_valid[u]), 32'(n != 0));
      if (n != 0) check($sformatf("%s u%0d rd_data", tag, u), 32'(rd_data[u]), 32'(q[0]));
    end
  endtask

  // One clock cycle on instance u: drive, clock, advance the model, compare.
  task automatic step(input int u, input bit rst_b, input bit w, input bit r,
                      input bit clr, input logic [7:0] d, input string tag);
    bit r_ok;
    bit w_ok;
    rst[u]     = rst_b;
    w_inc[u]   = w;
    r_inc[u]   = r;
    clr_err[u] = clr;
    wr_data[u] = d;
    @(posedge clk);
    if (!rst_b) begin
      q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      rv_m  = 1'b0;
      rd_m  = '0;
    end else begin
      r_ok  = r && (q.size() != 0);
      w_ok  = w && ((q.size() < depth_m) || r_ok);
      rv_m  = 1'b0;
      if (r_ok) begin
        rd_m = q.pop_front();
        rv_m = 1'b1;
      end
      if (w_ok) q.push_back(d);
      ovf_m = (w && !w_ok) || (ovf_m && !clr);
      unf_m = (r && !r_ok) || (unf_m && !clr);
    end
    #1;
    compare(u, tag);
    w_inc[u]   = 1'b0;
    r_inc[u]   = 1'b0;
    clr_err[u] = 1'b0;
    rst[u]     = 1'b1;
  endtask

  task automatic random_run(input int u, input int cycles);
    int wp;
    for (int i = 0; i < cycles; i++) begin
      // Swing between write-heavy and read-heavy to visit full and empty.
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      step(u, ($urandom_range(0, 63) != 0),
           ($urandom_range(0, 99) < wp),
           ($urandom_range(0, 99) >= wp),
           ($urandom_range(0, 15) == 0),
           8'($urandom), "rand");
    end
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = '0;
    w_inc      = '0;
    r_inc      = '0;
    clr_err    = '0;
    wr_data    = '0;
    drain_exp  = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hA0, 8'hA1, 8'hA2};
    @(posedge clk);
    #1;
    rst = '1;

    // ---------------- instance 0: defaults, registered read ----------------
    configure(8, 6, 2, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset");
    check("reset rd_data", 32'(rd_data[0]), 32'h0);
    check("reset empty",   32'(empty[0]),   32'h1);

    for (int i = 1; i <= 8; i++) begin
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), "fill");
      check($sformatf("fill count %0d", i), 32'(count[0]), 32'(i));
      check($sformatf("fill afull %0d", i), 32'(afull[0]), 32'(i >= 6));
    end
    check("full at 8", 32'(full[0]), 32'h1);

    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, "overflow");
    check("overflow set", 32'(ovf[0]), 32'h1);

    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(8'hA0 + i), "full rw");
      check($sformatf("full rw data %0d", i), 32'(rd_data[0]), 32'(8'h01 + i));
      check($sformatf("full rw count %0d", i), 32'(count[0]), 32'd8);
    end

    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "drain");
      check($sformatf("drain data %0d", i), 32'(rd_data[0]), 32'(drain_exp[i]));
      check($sformatf("drain valid %0d", i), 32'(rd_valid[0]), 32'h1);
    end
    check("empty after drain", 32'(empty[0]), 32'h1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "idle");
    check("valid drops", 32'(rd_valid[0]), 32'h0);

    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "underflow");
    check("underflow set", 32'(unf[0]), 32'h1);
    // A rejection and a clear in the same cycle: set wins for UNDERFLOW.
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "set vs clr");
    check("set beats clr", 32'(unf[0]), 32'h1);
    check("ovf cleared",   32'(ovf[0]), 32'h0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "clr");
    check("unf cleared",   32'(unf[0]), 32'h0);

    // Empty FIFO with read and write together: write lands, read rejected.
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, "empty rw");
    check("empty rw count", 32'(count[0]), 32'h1);
    check("empty rw unf",   32'(unf[0]),   32'h1);

    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "fill4");
    check("fill4 count", 32'(count[0]), 32'd4);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, "mid reset");
    check("mid reset count", 32'(count[0]), 32'h0);
    check("mid reset empty", 32'(empty[0]), 32'h1);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, "post reset wr");
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "post reset rd");
    check("post reset data", 32'(rd_data[0]), 32'h77);

    random_run(0, 400);

    // ---------------- instance 1: depth 5 ----------------
    configure(5, 4, 1, 1'b0);
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset d5");
    for (int i = 0; i < 12; i++) begin
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "d5 wr");
      step(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "d5 rd");
      check($sformatf("d5 wrap data %0d", i), 32'(rd_data[1]), 32'(8'h10 + i));
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i), "d5 fill");
      check($sformatf("d5 full %0d", i), 32'(full[1]), 32'(i == 4));
    end
    step(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, "d5 overflow");
    check("d5 overflow", 32'(ovf[1]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "d5 drain");
      check($sformatf("d5 drain data %0d", i), 32'(rd_data[1]), 32'(8'h60 + i));
    end

    random_run(1, 400);

    // ---------------- instance 2: FWFT ----------------
    configure(8, 6, 2, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset fw");
    check("fw reset valid", 32'(rd_valid[2]), 32'h0);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, "fw write");
    check("fw valid", 32'(rd_valid[2]), 32'h1);
    check("fw data",  32'(rd_data[2]),  32'h5A);
    step(2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "fw pop");
    check("fw pop empty", 32'(empty[2]),    32'h1);
    check("fw pop valid", 32'(rd_valid[2]), 32'h0);

    random_run(2, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
